// File: rtl/ans_freq_table.sv
// ANS symbol frequency table: loads per-symbol counts as a nibble stream, then builds inclusive prefix sums.
// Optional build macro ANS_TABLE_CHECK_EN adds a zero-count / empty-table check that drives err.
module ans_freq_table #(
  parameter int SYM_WIDTH = 4,
  parameter int CNT_WIDTH = 8,
  parameter int SYM_COUNT = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   ena,
  input  logic                                   start,
  input  logic [SYM_WIDTH-1:0]                   in,
  input  logic                                   in_vld,
  output logic                                   in_rdy,
  output logic [CNT_WIDTH*SYM_COUNT-1:0]         counts_unpacked,
  output logic [(CNT_WIDTH+SYM_WIDTH)*SYM_COUNT-1:0] cumulative_unpacked,
  output logic                                   table_vld,
  output logic                                   err
);

  localparam int NPC    = CNT_WIDTH / SYM_WIDTH;
  localparam int NIB_W  = (NPC > 1) ? $clog2(NPC) : 1;
  localparam int SIDX_W = (SYM_COUNT > 1) ? $clog2(SYM_COUNT) : 1;
  localparam int CUM_W  = CNT_WIDTH + SYM_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, ACCUM, DONE} state_t;

  state_t                 state, state_nxt;
  logic [NIB_W-1:0]       nib_idx;
  logic [SIDX_W-1:0]      sym_idx;
  logic [CNT_WIDTH-1:0]   cnt [SYM_COUNT];
  logic [CUM_W-1:0]       cum [SYM_COUNT];
  logic [CUM_W-1:0]       acc;
  logic [CUM_W-1:0]       acc_nxt;
  logic                   accept;
  logic                   last_nib;
  logic                   last_sym;
  logic                   restart;

  assign in_rdy    = (state == LOAD);
  assign table_vld = (state == DONE);
  assign accept    = ena && in_vld && (state == LOAD);
  assign restart   = start && ((state == IDLE) || (state == DONE));
  assign last_nib  = (nib_idx == NIB_W'(NPC - 1));
  assign last_sym  = (sym_idx == SIDX_W'(SYM_COUNT - 1));
  assign acc_nxt   = acc + {{SYM_WIDTH{1'b0}}, cnt[sym_idx]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = LOAD;
      LOAD:       if (accept && last_nib && last_sym) state_nxt = ACCUM;
      ACCUM:      if (last_sym) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Load stage writes nibbles LSB-first; accumulate stage walks the symbols one per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      nib_idx <= '0;
      sym_idx <= '0;
      acc     <= '0;
      for (int j = 0; j < SYM_COUNT; j++) begin
        cnt[j] <= '0;
        cum[j] <= '0;
      end
    end else if (ena) begin
      if (restart) begin
        nib_idx <= '0;
        sym_idx <= '0;
        acc     <= '0;
      end else if (accept) begin
        cnt[sym_idx][nib_idx*SYM_WIDTH +: SYM_WIDTH] <= in;
        if (last_nib) begin
          nib_idx <= '0;
          sym_idx <= last_sym ? '0 : sym_idx + SIDX_W'(1);
        end else begin
          nib_idx <= nib_idx + NIB_W'(1);
        end
      end else if (state == ACCUM) begin
        cum[sym_idx] <= acc_nxt;
        acc          <= acc_nxt;
        sym_idx      <= last_sym ? '0 : sym_idx + SIDX_W'(1);
      end
    end
  end

  for (genvar j = 0; j < SYM_COUNT; j++) begin : g_pack
    assign counts_unpacked[j*CNT_WIDTH +: CNT_WIDTH] = cnt[j];
    assign cumulative_unpacked[j*CUM_W +: CUM_W]     = cum[j];
  end

`ifdef ANS_TABLE_CHECK_EN
  logic err_q;
  logic any_zero;

  always_comb begin
    any_zero = 1'b0;
    for (int j = 0; j < SYM_COUNT; j++) begin
      if (cnt[j] == '0) any_zero = 1'b1;
    end
  end

  // Check is evaluated on the final accumulate cycle so err is valid on DONE entry
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (ena) begin
      if (restart) begin
        err_q <= 1'b0;
      end else if ((state == ACCUM) && last_sym) begin
        err_q <= (acc_nxt == '0) || any_zero;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ans_freq_table.sv
// Directed bench for ans_freq_table with a 4-symbol table of 8-bit counts.
module tb_ans_freq_table;

  localparam int SW = 4;
  localparam int CW = 8;
  localparam int SC = 4;
`ifdef ANS_TABLE_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    ena;
  logic                    start;
  logic [SW-1:0]           in_nib;
  logic                    in_vld;
  logic                    in_rdy;
  logic [CW*SC-1:0]        counts;
  logic [(CW+SW)*SC-1:0]   cum;
  logic                    table_vld;
  logic                    err;

  int checks   = 0;
  int failures = 0;

  ans_freq_table #(.SYM_WIDTH(SW), .CNT_WIDTH(CW), .SYM_COUNT(SC)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start),
    .in(in_nib), .in_vld(in_vld), .in_rdy(in_rdy),
    .counts_unpacked(counts), .cumulative_unpacked(cum),
    .table_vld(table_vld), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_rdy"}, 64'(in_rdy), 64'd1);
    chk({tag, "_vld_low"}, 64'(table_vld), 64'd0);
  endtask

  task automatic load(input logic [7:0] c0, c1, c2, c3, input bit gaps);
    logic [7:0] cs [4];
    cs = '{c0, c1, c2, c3};
    for (int s = 0; s < 4; s++) begin
      for (int n = 0; n < 2; n++) begin
        if (gaps) begin
          in_vld = 1'b0;
          in_nib = 4'hF;
          step();
        end
        in_nib = cs[s][n*4 +: 4];
        in_vld = 1'b1;
        step();
      end
    end
    in_vld = 1'b0;
    in_nib = 4'h0;
  endtask

  task automatic wait_vld(input string tag, input int already, input int exp_lat);
    int n;
    n = already;
    while (!table_vld && n < 30) begin
      step();
      n++;
    end
    chk(tag, 64'(n), 64'(exp_lat));
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; start = 1'b0; in_vld = 1'b1; in_nib = 4'hA;
    step();
    step();
    chk("rst_rdy", 64'(in_rdy), 64'd0);
    chk("rst_vld", 64'(table_vld), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_counts", 64'(counts), 64'd0);
    chk("rst_cum", 64'(cum), 64'd0);
    rst = 1'b0; ena = 1'b1;
    step();
    chk("idle_vld_ignored", 64'(in_rdy), 64'd0);
    in_vld = 1'b0;

    // Basic load {3,5,0,8}
    do_start("t1");
    load(8'd3, 8'd5, 8'd0, 8'd8, 1'b0);
    chk("t1_rdy_drop", 64'(in_rdy), 64'd0);
    wait_vld("t1_latency", 0, 4);
    chk("t1_counts", 64'(counts), 64'({8'd8, 8'd0, 8'd5, 8'd3}));
    chk("t1_cum", 64'(cum), 64'({12'd16, 12'd8, 12'd8, 12'd3}));
    chk("t1_err", 64'(err), 64'(CHK_EN));
    in_vld = 1'b1; in_nib = 4'h7;
    step();
    step();
    in_vld = 1'b0;
    chk("done_vld_hold", 64'(table_vld), 64'd1);
    chk("done_cum_stable", 64'(cum), 64'({12'd16, 12'd8, 12'd8, 12'd3}));
    chk("done_rdy", 64'(in_rdy), 64'd0);

    // Gapped stream, ignored start in ACCUM, 3-cycle ena stall
    do_start("t2");
    load(8'd3, 8'd5, 8'd0, 8'd8, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    ena = 1'b0;
    step(); step(); step();
    chk("t2_stall_vld", 64'(table_vld), 64'd0);
    ena = 1'b1;
    wait_vld("t2_latency", 4, 7);
    chk("t2_counts", 64'(counts), 64'({8'd8, 8'd0, 8'd5, 8'd3}));
    chk("t2_cum", 64'(cum), 64'({12'd16, 12'd8, 12'd8, 12'd3}));

    // Reload {1,1,1,1} from DONE
    do_start("t3");
    load(8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
    wait_vld("t3_latency", 0, 4);
    chk("t3_cum", 64'(cum), 64'({12'd4, 12'd3, 12'd2, 12'd1}));
    chk("t3_err", 64'(err), 64'd0);

    // Reset after three nibbles, then a clean {2,2,2,2} load
    do_start("t4");
    for (int i = 0; i < 3; i++) begin
      in_nib = 4'h9; in_vld = 1'b1;
      step();
    end
    in_vld = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_rst_rdy", 64'(in_rdy), 64'd0);
    chk("t4_rst_vld", 64'(table_vld), 64'd0);
    chk("t4_rst_counts", 64'(counts), 64'd0);
    do_start("t4b");
    load(8'd2, 8'd2, 8'd2, 8'd2, 1'b0);
    wait_vld("t4_latency", 0, 4);
    chk("t4_counts", 64'(counts), 64'({8'd2, 8'd2, 8'd2, 8'd2}));
    chk("t4_cum", 64'(cum), 64'({12'd8, 12'd6, 12'd4, 12'd2}));
    chk("t4_err", 64'(err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
